// File: rtl/video_pkg.sv
// Constants shared by the video block stages (row packer and block transpose).
package video_pkg;
  localparam int BLOCK_DIM         = 8;
  localparam int BLOCK_COEFS       = BLOCK_DIM * BLOCK_DIM;
  localparam int ROW_IDX_WIDTH     = $clog2(BLOCK_DIM);
  localparam int STREAM_ID_WIDTH   = 4;
  localparam int STREAM_DEST_WIDTH = 4;
  localparam int STREAM_USER_WIDTH = 8;
endpackage

// File: rtl/nasti_stream_channel.sv
// Stream channel bundle.
// Handshake: a beat transfers on a rising clock edge where t_valid and t_ready
// are both 1; the master holds t_valid and every payload field stable until then.
interface nasti_stream_channel #(
  parameter int N_PORT     = 1,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 8
);
  logic                                     t_valid;
  logic                                     t_ready;
  logic [N_PORT-1:0][DATA_WIDTH-1:0]        t_data;
  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]      t_keep;
  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]      t_strb;
  logic                                     t_last;
  logic [ID_WIDTH-1:0]                      t_id;
  logic [DEST_WIDTH-1:0]                    t_dest;
  logic [USER_WIDTH-1:0]                    t_user;

  modport master (
    output t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/row_pack_stream.sv
// Packs eight coefficient rows into one 8x8 block beat for the transpose stage.
// A t_last before row 7 closes the block early; unwritten rows read as zero.
module row_pack_stream
  import video_pkg::*;
#(
  parameter int COEF_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  nasti_stream_channel.slave        in_ch,
  nasti_stream_channel.master       out_ch
);
  localparam int ROW_WIDTH   = BLOCK_DIM * COEF_WIDTH;
  localparam int BLOCK_WIDTH = BLOCK_COEFS * COEF_WIDTH;

  logic [ROW_WIDTH-1:0]         rows_q [BLOCK_DIM];
  logic [ROW_IDX_WIDTH-1:0]     row_cnt;
  logic [BLOCK_DIM-1:0]         written;
  logic                         out_valid;
  logic [STREAM_ID_WIDTH-1:0]   id_q;
  logic [STREAM_DEST_WIDTH-1:0] dest_q;
  logic [STREAM_USER_WIDTH-1:0] user_q;
  logic [BLOCK_WIDTH-1:0]       block_data;

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic block_done;
  logic unused_in;

  // The buffer is free once the pending block leaves on this same edge.
  assign in_ready   = !out_valid || out_ch.t_ready;
  assign in_fire    = in_ch.t_valid && in_ready;
  assign out_fire   = out_valid && out_ch.t_ready;
  assign block_done = in_fire &&
                      ((row_cnt == ROW_IDX_WIDTH'(BLOCK_DIM - 1)) || in_ch.t_last);
  assign unused_in  = ^{in_ch.t_keep, in_ch.t_strb};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < BLOCK_DIM; r++) rows_q[r] <= '0;
      row_cnt   <= '0;
      written   <= '0;
      out_valid <= 1'b0;
      id_q      <= '0;
      dest_q    <= '0;
      user_q    <= '0;
    end else begin
      if (in_fire) begin
        rows_q[row_cnt] <= in_ch.t_data[0][ROW_WIDTH-1:0];
        row_cnt         <= block_done ? '0 : row_cnt + ROW_IDX_WIDTH'(1);
        if (row_cnt == '0) begin
          written <= BLOCK_DIM'(1);
          id_q    <= in_ch.t_id;
          dest_q  <= in_ch.t_dest;
          user_q  <= in_ch.t_user;
        end else begin
          written[row_cnt] <= 1'b1;
        end
      end
      if (block_done) out_valid <= 1'b1;
      else if (out_fire) out_valid <= 1'b0;
    end
  end

  // Rows left over from an earlier block are masked so a short block reads zero.
  always_comb begin
    block_data = '0;
    for (int r = 0; r < BLOCK_DIM; r++) begin
      block_data[r*ROW_WIDTH +: ROW_WIDTH] = written[r] ? rows_q[r] : '0;
    end
  end

  assign in_ch.t_ready     = in_ready;
  assign out_ch.t_valid    = out_valid;
  assign out_ch.t_data[0]  = block_data;
  assign out_ch.t_keep[0]  = '1;
  assign out_ch.t_strb[0]  = '1;
  assign out_ch.t_last     = 1'b1;
  assign out_ch.t_id       = id_q;
  assign out_ch.t_dest     = dest_q;
  assign out_ch.t_user     = user_q;
endmodule

// File: tb/tb_row_pack_stream.sv
// Bench for row_pack_stream: queue-based block model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_row_pack_stream;
  import video_pkg::*;

  localparam int CW     = 32;
  localparam int ROW_W  = BLOCK_DIM * CW;
  localparam int BLK_W  = BLOCK_COEFS * CW;
  localparam int ID_W   = STREAM_ID_WIDTH;
  localparam int DEST_W = STREAM_DEST_WIDTH;
  localparam int USER_W = STREAM_USER_WIDTH;
  localparam int SB_W   = ID_W + DEST_W + USER_W;
  localparam int W      = BLK_W + SB_W;

  logic aclk = 1'b0;
  logic aresetn;

  nasti_stream_channel #(.DATA_WIDTH(ROW_W), .ID_WIDTH(ID_W), .DEST_WIDTH(DEST_W),
                         .USER_WIDTH(USER_W)) in_if ();
  nasti_stream_channel #(.DATA_WIDTH(BLK_W), .ID_WIDTH(ID_W), .DEST_WIDTH(DEST_W),
                         .USER_WIDTH(USER_W)) out_if ();

  row_pack_stream #(.COEF_WIDTH(CW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_ch   (in_if),
    .out_ch  (out_if)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  logic [ROW_W-1:0] part_q[$];
  logic [SB_W-1:0]  part_sb;
  logic [W-1:0]     last_out;
  logic [W-1:0]     got;
  logic [W-1:0]     blk;
  int               in_cycles[$];
  int               out_cycles[$];
  int               out_beats = 0;
  int               vectors = 0;
  int               miscompares = 0;
  logic             exp_valid;
  logic             exp_rdy;

  function automatic logic [CW-1:0] coef(input logic [W-1:0] b, input int k);
    return b[k*CW +: CW];
  endfunction

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < BLOCK_COEFS; k++) if (a[k*CW +: CW] !== b[k*CW +: CW]) return k;
    return -1;
  endfunction

  function automatic logic [ROW_W-1:0] seq_row(input int base);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < BLOCK_DIM; c++) r[c*CW +: CW] = CW'(base + c);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] fill_row(input int v);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < BLOCK_DIM; c++) r[c*CW +: CW] = CW'(v);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < BLOCK_DIM; c++) r[c*CW +: CW] = CW'($urandom);
    return r;
  endfunction

  // ---------------- compare process + block model ----------------
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      part_q.delete();
      exp_q.delete();
    end
    exp_valid = (exp_q.size() != 0);
    exp_rdy   = !exp_valid || out_if.t_ready;
    got       = {out_if.t_user, out_if.t_dest, out_if.t_id, out_if.t_data[0]};

    vectors++;
    if (out_if.t_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL out_valid @%0d: got %b exp %b", cyc, out_if.t_valid, exp_valid);
    end
    vectors++;
    if (in_if.t_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL in_ready @%0d: got %b exp %b", cyc, in_if.t_ready, exp_rdy);
    end
    if (exp_valid) begin
      vectors++;
      if (got !== exp_q[0]) begin
        miscompares++;
        $display("FAIL payload @%0d: coef %0d got %h exp %h, sideband got %h exp %h",
                 cyc, first_diff(got, exp_q[0]),
                 coef(got, first_diff(got, exp_q[0])), coef(exp_q[0], first_diff(got, exp_q[0])),
                 got[BLK_W +: SB_W], exp_q[0][BLK_W +: SB_W]);
      end
      vectors++;
      if (out_if.t_last !== 1'b1 || out_if.t_keep[0] !== {(BLK_W/8){1'b1}} ||
          out_if.t_strb[0] !== {(BLK_W/8){1'b1}}) begin
        miscompares++;
        $display("FAIL last_keep_strb @%0d: got last=%b keep_ones=%b strb_ones=%b exp 1 1 1",
                 cyc, out_if.t_last, &out_if.t_keep[0], &out_if.t_strb[0]);
      end
    end

    // advance the model to the coming rising edge
    if (aresetn) begin
      if (exp_valid && out_if.t_ready) begin
        last_out = got;
        out_beats++;
        out_cycles.push_back(cyc + 1);
        exp_q.delete(0);
      end
      if (in_if.t_valid && exp_rdy) begin
        in_cycles.push_back(cyc + 1);
        if (part_q.size() == 0) part_sb = {in_if.t_user, in_if.t_dest, in_if.t_id};
        part_q.push_back(in_if.t_data[0]);
        if (part_q.size() == BLOCK_DIM || in_if.t_last) begin
          blk = '0;
          foreach (part_q[r]) blk[r*ROW_W +: ROW_W] = part_q[r];
          blk[BLK_W +: SB_W] = part_sb;
          exp_q.push_back(blk);
          part_q.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_row(input logic [ROW_W-1:0] d, input logic last,
                          input logic [ID_W-1:0] id, input logic [DEST_W-1:0] dest,
                          input logic [USER_W-1:0] user);
    bit fire;
    int n;
    fire = 1'b0;
    n = 0;
    in_if.t_data[0] = d;
    in_if.t_last    = last;
    in_if.t_id      = id;
    in_if.t_dest    = dest;
    in_if.t_user    = user;
    in_if.t_keep[0] = $urandom;
    in_if.t_strb[0] = $urandom;
    in_if.t_valid   = 1'b1;
    while (!fire && n < 100) begin
      @(negedge aclk);
      fire = in_if.t_ready;
      @(posedge aclk);
      #1;
      n++;
    end
    in_if.t_valid = 1'b0;
    vectors++;
    if (!fire) begin
      miscompares++;
      $display("FAIL send_timeout: got no acceptance in %0d cycles, exp acceptance", n);
    end
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_beats < target && n < 200) begin
      @(posedge aclk);
      n++;
    end
    #1;
    vectors++;
    if (out_beats < target) begin
      miscompares++;
      $display("FAIL out_timeout: got %0d beats exp %0d", out_beats, target);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input longint got_v, input longint exp_v);
    vectors++;
    if (got_v != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d exp %0d", name, got_v, exp_v);
    end
  endtask

  // ---------------- stimulus ----------------
  int ib, ob, b0, r_cyc;
  int vals[3];

  initial begin
    aresetn         = 1'b1;
    in_if.t_valid   = 1'b0;
    in_if.t_data    = '0;
    in_if.t_keep    = '0;
    in_if.t_strb    = '0;
    in_if.t_last    = 1'b0;
    in_if.t_id      = '0;
    in_if.t_dest    = '0;
    in_if.t_user    = '0;
    out_if.t_ready  = 1'b1;
    #2 aresetn = 1'b0;

    // reset state
    @(negedge aclk);
    check("reset_out_valid", out_if.t_valid, 0);
    check("reset_in_ready", in_if.t_ready, 1);
    check("reset_data_zero", (out_if.t_data[0] == '0) ? 1 : 0, 1);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    idle(2);

    // row packing: value 8r+c lands at index k = 8r+c
    ib = in_cycles.size();
    ob = out_beats;
    for (int r = 0; r < BLOCK_DIM; r++) send_row(seq_row(8 * r), r == 7, 1, 2, 3);
    wait_out(ob + 1);
    for (int k = 0; k < BLOCK_COEFS; k++) check($sformatf("pack_k%0d", k), coef(last_out, k), k);
    check("pack_latency", out_cycles[out_cycles.size() - 1] - in_cycles[ib + 7], 1);

    // backpressure: block stays presented for 5 stalled cycles
    out_if.t_ready = 1'b0;
    ob = out_beats;
    for (int r = 0; r < BLOCK_DIM; r++) send_row(rand_row(), 1'b0, 4, 1, 9);
    repeat (5) begin
      @(negedge aclk);
      check("bp_in_ready", in_if.t_ready, 0);
      check("bp_out_valid", out_if.t_valid, 1);
      @(posedge aclk);
      #1;
    end
    out_if.t_ready = 1'b1;
    r_cyc = cyc;
    wait_out(ob + 1);
    check("bp_accept_cycle", out_cycles[out_cycles.size() - 1], r_cyc + 1);

    // back-to-back: 24 rows, valid held high
    ib = in_cycles.size();
    ob = out_cycles.size();
    for (int r = 0; r < 3 * BLOCK_DIM; r++) send_row(rand_row(), (r % 8) == 7, 0, 0, 0);
    wait_out(out_beats + (ob + 3 - out_cycles.size()));
    check("b2b_out_count", out_cycles.size() - ob, 3);
    if (out_cycles.size() - ob == 3)
      for (int i = 0; i < 3; i++)
        check($sformatf("b2b_out_cycle%0d", i), out_cycles[ob + i] - in_cycles[ib] + 1, 9 + 8 * i);
    check("b2b_no_stall", in_cycles[ib + 23] - in_cycles[ib], 23);

    // early t_last after 3 rows
    vals = '{32'h11, 32'h22, 32'h33};
    ob = out_beats;
    for (int r = 0; r < 3; r++) send_row(fill_row(vals[r]), r == 2, 0, 0, 0);
    wait_out(ob + 1);
    for (int r = 0; r < BLOCK_DIM; r++)
      check($sformatf("early_row%0d", r), coef(last_out, 8 * r + 5), (r < 3) ? vals[r] : 0);
    ob = out_beats;
    for (int r = 0; r < BLOCK_DIM; r++) send_row(seq_row(100 + 8 * r), 1'b0, 0, 0, 0);
    wait_out(ob + 1);
    check("after_early_k0", coef(last_out, 0), 100);
    check("after_early_k63", coef(last_out, 63), 163);

    // sideband from row 0
    ob = out_beats;
    send_row(rand_row(), 1'b0, 5, 3, 8'h0A);
    for (int r = 1; r < BLOCK_DIM; r++) send_row(rand_row(), 1'b0, 7, 2, 8'h01);
    wait_out(ob + 1);
    check("sb_id", last_out[BLK_W +: ID_W], 5);
    check("sb_dest", last_out[BLK_W + ID_W +: DEST_W], 3);
    check("sb_user", last_out[BLK_W + ID_W + DEST_W +: USER_W], 8'h0A);

    // reset mid-block discards the partial block
    b0 = out_beats;
    for (int r = 0; r < 4; r++) send_row(fill_row(32'hDEAD), 1'b0, 0, 0, 0);
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
    idle(1);
    for (int r = 0; r < BLOCK_DIM; r++) send_row(seq_row(200 + 8 * r), 1'b0, 0, 0, 0);
    wait_out(b0 + 1);
    idle(10);
    check("rst_block_count", out_beats - b0, 1);
    check("rst_k0", coef(last_out, 0), 200);
    check("rst_k31", coef(last_out, 31), 231);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      out_if.t_ready  = ($urandom_range(0, 3) != 0);
      in_if.t_valid   = ($urandom_range(0, 9) < 7);
      in_if.t_data[0] = rand_row();
      in_if.t_last    = ($urandom_range(0, 7) == 0);
      in_if.t_id      = ID_W'($urandom);
      in_if.t_dest    = DEST_W'($urandom);
      in_if.t_user    = USER_W'($urandom);
      in_if.t_keep[0] = $urandom;
      in_if.t_strb[0] = $urandom;
      @(posedge aclk);
      #1;
    end
    in_if.t_valid  = 1'b0;
    out_if.t_ready = 1'b1;
    idle(20);
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/row_pack_stream.md
ROW_PACK_STREAM -- requirements
Module: row_pack_stream

Interface
REQ-001 SHALL have parameter COEF_WIDTH, default 32, giving the width in bits of one signed coefficient.
REQ-002 SHALL have port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_ch, nasti_stream_channel.slave, interface: one 8-coefficient row per beat in t_data[0][8*COEF_WIDTH-1:0], coefficient c at bits [(c+1)*COEF_WIDTH-1 : c*COEF_WIDTH].
REQ-005 SHALL have port out_ch, nasti_stream_channel.master, interface: one 8x8 block per beat in t_data[0][64*COEF_WIDTH-1:0], row-major, with row r, column c at index 8*r+c; feeds the block transpose stage.

Function
REQ-006 SHALL treat an in_ch beat as accepted when t_valid and t_ready are both 1; SHALL treat an out_ch beat as accepted when t_valid and t_ready are both 1.
REQ-007 SHALL keep a 3-bit row counter, 0..7, that selects the destination row of the next accepted input beat.
REQ-008 SHALL write an accepted row into buffer row = counter, then increment the counter, wrapping from 7 to 0.
REQ-009 SHALL set out_ch.t_valid on the clock edge that accepts row 7, so the block is presented one cycle after its last row.
REQ-010 SHALL hold out_ch.t_valid and all out_ch payload stable until out_ch accepts the beat.
REQ-011 SHALL drive in_ch.t_ready = !out_ch.t_valid || out_ch.t_ready, combinationally.
REQ-012 SHALL, when out_ch accepts a beat and in_ch accepts row 0 in the same cycle, clear out_ch.t_valid and write row 0 of the new block on that edge, with no bubble.
REQ-013 SHALL sustain full throughput: 8 input beats per output beat, with no idle cycles, while out_ch.t_ready is 1.
REQ-014 SHALL capture t_id, t_dest and t_user from row 0 of each block and present them on out_ch with that block.
REQ-015 SHALL drive out_ch.t_last = 1 on every output beat; each block is one packet.
REQ-016 SHALL drive out_ch.t_keep and out_ch.t_strb all-ones across the 64*COEF_WIDTH bits.
REQ-017 SHALL ignore in_ch t_keep and t_strb.
REQ-018 SHALL, on an accepted input beat with t_last = 1 and counter < 7, terminate the block early: set out_ch.t_valid on the next edge and reset the counter to 0.
REQ-019 SHALL present every row not written in the current block (early termination) as zero; SHALL keep a per-row written mask, cleared on each row-0 write, for this purpose.
REQ-020 SHALL treat t_last on row 7 as normal completion.
REQ-021 SHALL pass coefficients bit-exact, with no arithmetic and no sign change.

Reset
REQ-022 SHALL, while aresetn = 0, force: out_ch.t_valid = 0, row counter = 0, written mask = 0, buffer = 0, captured sideband = 0.
REQ-023 SHALL, when reset is asserted mid-block, discard the partial block; the first row accepted after reset is row 0 of a new block.
REQ-024 SHALL keep in_ch.t_ready = 1 while out_ch.t_valid = 0, including during reset.

Structure
REQ-025 SHALL take BLOCK_DIM = 8 and BLOCK_COEFS = 64 from the shared video package, which this stage and the transpose stage both use.
REQ-026 SHALL be one flat module with no sub-module; the buffer is a plain register array of 8 rows of 8*COEF_WIDTH bits.

Verification
REQ-027 Row packing: send 8 rows with coefficient value = 8*r + c and out_ch.t_ready = 1 -> one output beat one cycle after row 7; index k holds value k; t_last = 1.
REQ-028 Backpressure: hold out_ch.t_ready = 0 for 5 cycles after the block is valid -> in_ch.t_ready = 0; payload unchanged; the block is accepted on the first cycle ready = 1.
REQ-029 Back-to-back: 3 blocks (24 rows) with t_valid = 1 throughout and ready = 1 -> exactly 3 output beats on cycles 9, 17 and 25 after the first acceptance; no input stall.
REQ-030 Early t_last: 3 rows of 0x11, 0x22, 0x33 with t_last on row 2 -> output rows 0..2 hold those values, rows 3..7 are zero; the next block starts at row 0.
REQ-031 Sideband: row 0 carries t_id = 5 and t_user = 0xA, later rows carry t_id = 7 -> the output block carries t_id = 5 and t_user = 0xA.
REQ-032 Mid-block reset: assert aresetn = 0 after 4 rows, then send 8 rows -> exactly one block, containing only the post-reset rows.
